// File: rtl/qam_sym_sched.sv
// 16-QAM symbol scheduler: gates the carrier generator, aligns symbol changes to
// carrier phase-zero strobes and drives Gray-mapped I/Q levels. Option: QAM_SCHED_UNDERRUN_CNT_EN.
module qam_sym_sched #(
    parameter int unsigned SYM_PERIODS = 1
) (
    input  logic       axi_clk,
    input  logic       axi_rst,
    input  logic       start,
    input  logic       stop,
    output logic       cor_en,
    input  logic       cor_zero,
    input  logic       s_sym_tvalid,
    output logic       s_sym_tready,
    input  logic [3:0] s_sym_tdata,
    output logic [2:0] m_i,
    output logic [2:0] m_q,
    output logic       m_sym_valid,
    output logic       underrun,
    output logic       busy
`ifdef QAM_SCHED_UNDERRUN_CNT_EN
    ,
    output logic [7:0] underrun_cnt
`endif
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LVL_W  = 3;
    localparam int unsigned UCNT_W = 8;
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(SYM_PERIODS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic [LVL_W-1:0]   m_i_d, m_q_d;
    logic               m_valid_d;
    logic               underrun_d;
    logic               fill_start_c;
    logic               sym_bound_c;
    logic               stop_bound_c;

    // Gray-coded 2-bit field to signed amplitude level
    function automatic logic [LVL_W-1:0] gray_lvl(input logic [1:0] g);
        logic [LVL_W-1:0] lvl;
        case (g)
            2'b00:   lvl = 3'b101;
            2'b01:   lvl = 3'b111;
            2'b11:   lvl = 3'b001;
            default: lvl = 3'b011;
        endcase
        return lvl;
    endfunction

    // Next-state, symbol-slot decode and output datapath
    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        stop_pend_d  = stop_pend_q;
        fill_start_c = 1'b0;
        sym_bound_c  = 1'b0;
        stop_bound_c = 1'b0;
        m_i_d        = m_i;
        m_q_d        = m_q;
        m_valid_d    = m_sym_valid;
        underrun_d   = 1'b0;
        s_sym_tready = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d      = FILL;
                    per_cnt_d    = '0;
                    stop_pend_d  = 1'b0;
                    fill_start_c = 1'b1;
                end
            end
            FILL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cor_zero) begin
                    state_d     = RUN;
                    per_cnt_d   = '0;
                    sym_bound_c = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (cor_zero) begin
                    if (per_cnt_q == PER_LAST) begin
                        per_cnt_d = '0;
                        if (stop_pend_q) begin
                            state_d      = IDLE;
                            stop_pend_d  = 1'b0;
                            stop_bound_c = 1'b1;
                        end else begin
                            sym_bound_c = 1'b1;
                        end
                    end else begin
                        per_cnt_d = per_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A symbol is never accepted in a reset cycle
        s_sym_tready = sym_bound_c && !axi_rst;

        if (sym_bound_c) begin
            if (s_sym_tvalid) begin
                m_i_d     = gray_lvl(s_sym_tdata[3:2]);
                m_q_d     = gray_lvl(s_sym_tdata[1:0]);
                m_valid_d = 1'b1;
            end else begin
                m_i_d      = '0;
                m_q_d      = '0;
                m_valid_d  = 1'b0;
                underrun_d = 1'b1;
            end
        end else if (stop_bound_c) begin
            m_i_d     = '0;
            m_q_d     = '0;
            m_valid_d = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q     <= IDLE;
            per_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            cor_en      <= 1'b0;
            busy        <= 1'b0;
            m_i         <= '0;
            m_q         <= '0;
            m_sym_valid <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            stop_pend_q <= stop_pend_d;
            cor_en      <= (state_d != IDLE);
            busy        <= (state_d != IDLE);
            m_i         <= m_i_d;
            m_q         <= m_q_d;
            m_sym_valid <= m_valid_d;
            underrun    <= underrun_d;
        end
    end

`ifdef QAM_SCHED_UNDERRUN_CNT_EN
    // Saturating underrun counter, restarted with each transmission
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            underrun_cnt <= '0;
        end else if (fill_start_c) begin
            underrun_cnt <= '0;
        end else if (underrun_d && (underrun_cnt != {UCNT_W{1'b1}})) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule
